// File: rtl/if_stage_pc.sv
// if_stage_pc: instruction-fetch stage.
// Owns the PC and issues one fetch at a time over a valid/ready request/response pair.
// Each fetched instruction goes to decode as {pc, inst} through a one-entry output slot.
// A branch/jump redirect (bj_ena/new_pc) flushes the slot and any fetch still in flight.
// Optional feature macro: IF_MISALIGN_CHK_EN.
//   Defined:   new_pc is used as given. The extra output if_misalign latches on a misaligned
//              redirect target and halts fetch until reset.
//   Undefined: new_pc[1:0] is forced to zero and fetch never halts.
module if_stage_pc #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] PC_START = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bj_ena,
  input  logic [XLEN-1:0] new_pc,
  output logic            if_req_valid,
  input  logic            if_req_ready,
  output logic [XLEN-1:0] if_req_addr,
  input  logic            if_rsp_valid,
  output logic            if_rsp_ready,
  input  logic [31:0]     if_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_inst
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic            if_misalign
`endif
);

  localparam logic S_REQ  = 1'b0;
  localparam logic S_WAIT = 1'b1;

  logic            state_reg;
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] req_pc_reg;
  logic            drop_reg;
  logic            id_valid_reg;
  logic [XLEN-1:0] id_pc_reg;
  logic [31:0]     id_inst_reg;

  logic            halt;
  logic [XLEN-1:0] redirect_pc;
  logic            req_hs;
  logic            rsp_hs;
  logic            rsp_keep;

`ifdef IF_MISALIGN_CHK_EN
  logic misalign_reg;

  // Sticky misaligned-redirect flag; it stops all further fetches until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_reg <= 1'b0;
    end else if (bj_ena && (new_pc[1:0] != 2'b00)) begin
      misalign_reg <= 1'b1;
    end
  end

  assign halt        = misalign_reg;
  assign if_misalign = misalign_reg;
  assign redirect_pc = new_pc;
`else
  assign halt        = 1'b0;
  assign redirect_pc = new_pc & ~XLEN'(3);
`endif

  // The request is gated by reset so that nothing is issued while rst is asserted.
  // It is also suppressed during a redirect, because the current pc is on the wrong path.
  assign if_req_valid = rst && (state_reg == S_REQ) && !bj_ena && !halt;
  assign if_req_addr  = pc_reg;
  assign if_rsp_ready = (state_reg == S_WAIT) &&
                        (drop_reg || bj_ena || !id_valid_reg || id_ready);

  assign req_hs   = if_req_valid && if_req_ready;
  assign rsp_hs   = if_rsp_valid && if_rsp_ready;
  // Only a response that is neither stale nor being redirected reaches decode.
  assign rsp_keep = rsp_hs && !drop_reg && !bj_ena;

  // Fetch FSM and the address of the outstanding request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_REQ;
      req_pc_reg <= '0;
    end else begin
      case (state_reg)
        S_REQ: begin
          if (req_hs) begin
            state_reg  <= S_WAIT;
            req_pc_reg <= pc_reg;
          end
        end
        default: begin
          if (rsp_hs) begin
            state_reg <= S_REQ;
          end
        end
      endcase
    end
  end

  // Stale-response marker.
  // It is set by a redirect while a response is still owed. It is cleared when that response drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_reg <= 1'b0;
    end else if (bj_ena && (state_reg == S_WAIT) && !rsp_hs) begin
      drop_reg <= 1'b1;
    end else if (rsp_hs) begin
      drop_reg <= 1'b0;
    end
  end

  // PC update.
  // A redirect wins. Otherwise the PC advances only when a kept response returns.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= PC_START;
    end else if (bj_ena) begin
      pc_reg <= redirect_pc;
    end else if (rsp_kep_guard(rsp_keep)) begin
      pc_reg <= req_pc_reg + XLEN'(4);
    end
  end

  function automatic logic rsp_kep_guard(input logic k);
    return k;
  endfunction

  // Output slot.
  // A redirect flushes it. A kept response refills it. Decode drains it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_reg <= 1'b0;
      id_pc_reg    <= '0;
      id_inst_reg  <= '0;
    end else if (bj_ena) begin
      id_valid_reg <= 1'b0;
    end else if (rsp_keep) begin
      id_valid_reg <= 1'b1;
      id_pc_reg    <= req_pc_reg;
      id_inst_reg  <= if_rsp_data;
    end else if (id_ready) begin
      id_valid_reg <= 1'b0;
    end
  end

  assign id_valid = id_valid_reg;
  assign id_pc    = id_pc_reg;
  assign id_inst  = id_inst_reg;

endmodule

// File: tb/tb_if_stage_pc.sv
// Directed testbench for if_stage_pc.
// Memory and decode behaviour is driven by hand, cycle by cycle.
// Every expected value is a hand-computed constant.
module tb_if_stage_pc;

  logic        clk = 1'b0;
  logic        rst;
  logic        bj_ena;
  logic [63:0] new_pc;
  logic        if_req_valid;
  logic        if_req_ready;
  logic [63:0] if_req_addr;
  logic        if_rsp_valid;
  logic        if_rsp_ready;
  logic [31:0] if_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  logic [31:0] id_inst;
`ifdef IF_MISALIGN_CHK_EN
  logic        if_misalign;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  if_stage_pc dut (
    .clk          (clk),
    .rst          (rst),
    .bj_ena       (bj_ena),
    .new_pc       (new_pc),
    .if_req_valid (if_req_valid),
    .if_req_ready (if_req_ready),
    .if_req_addr  (if_req_addr),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_ready (if_rsp_ready),
    .if_rsp_data  (if_rsp_data),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_inst      (id_inst)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .if_misalign  (if_misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one complete fetch, starting in S_REQ.
  // The request is accepted at once, and the response comes back one cycle later.
  task automatic do_fetch(input string tag, input logic [63:0] addr, input logic [31:0] data);
    check({tag, ".req_valid"}, {63'd0, if_req_valid}, 64'd1);
    check({tag, ".req_addr"}, if_req_addr, addr);
    if_req_ready = 1'b1;
    step();
    if_req_ready = 1'b0;
    if_rsp_valid = 1'b1;
    if_rsp_data  = data;
    #1;
    check({tag, ".rsp_ready"}, {63'd0, if_rsp_ready}, 64'd1);
    step();
    if_rsp_valid = 1'b0;
    #1;
    check({tag, ".id_valid"}, {63'd0, id_valid}, 64'd1);
    check({tag, ".id_pc"}, id_pc, addr);
    check({tag, ".id_inst"}, {32'd0, id_inst}, {32'd0, data});
  endtask

  initial begin
    rst          = 1'b0;
    bj_ena       = 1'b0;
    new_pc       = 64'd0;
    if_req_ready = 1'b0;
    if_rsp_valid = 1'b0;
    if_rsp_data  = 32'd0;
    id_ready     = 1'b1;

    // Reset state
    #2;
    check("rst.req_valid", {63'd0, if_req_valid}, 64'd0);
    check("rst.rsp_ready", {63'd0, if_rsp_ready}, 64'd0);
    check("rst.id_valid", {63'd0, id_valid}, 64'd0);
    check("rst.id_pc", id_pc, 64'd0);
    check("rst.id_inst", {32'd0, id_inst}, 64'd0);
    #10;
    rst = 1'b1;
    step();

    // 1: sequential fetches from PC_START
    do_fetch("t1.f0", 64'h8000_0000, 32'h0000_0013);
    do_fetch("t1.f1", 64'h8000_0004, 32'h0010_0093);
    do_fetch("t1.f2", 64'h8000_0008, 32'h0020_0113);

    // 2: backpressure from decode
    id_ready = 1'b0;
    #1;
    check("t2.req_addr", if_req_addr, 64'h8000_000C);
    if_req_ready = 1'b1;
    step();
    if_req_ready = 1'b0;
    if_rsp_valid = 1'b1;
    if_rsp_data  = 32'h0030_0193;
    #1;
    check("t2.rsp_ready_blocked", {63'd0, if_rsp_ready}, 64'd0);
    step();
    step();
    check("t2.hold_valid", {63'd0, id_valid}, 64'd1);
    check("t2.hold_pc", id_pc, 64'h8000_0008);
    check("t2.hold_inst", {32'd0, id_inst}, 64'h0020_0113);
    check("t2.still_blocked", {63'd0, if_rsp_ready}, 64'd0);
    id_ready = 1'b1;
    #1;
    check("t2.rsp_ready_free", {63'd0, if_rsp_ready}, 64'd1);
    step();
    if_rsp_valid = 1'b0;
    #1;
    check("t2.refill_valid", {63'd0, id_valid}, 64'd1);
    check("t2.refill_pc", id_pc, 64'h8000_000C);
    check("t2.refill_inst", {32'd0, id_inst}, 64'h0030_0193);
    check("t2.next_addr", if_req_addr, 64'h8000_0010);

    // 3: redirect while waiting; the stale response arrives three cycles later
    if_req_ready = 1'b1;
    step();
    if_req_ready = 1'b0;
    bj_ena = 1'b1;
    new_pc = 64'h8000_1000;
    #1;
    check("t3.req_valid_bj", {63'd0, if_req_valid}, 64'd0);
    step();
    bj_ena = 1'b0;
    step();
    check("t3.wait_req_valid", {63'd0, if_req_valid}, 64'd0);
    check("t3.drop_rsp_ready", {63'd0, if_rsp_ready}, 64'd1);
    step();
    if_rsp_valid = 1'b1;
    if_rsp_data  = 32'hDEAD_BEEF;
    step();
    if_rsp_valid = 1'b0;
    #1;
    check("t3.id_valid", {63'd0, id_valid}, 64'd0);
    check("t3.req_valid", {63'd0, if_req_valid}, 64'd1);
    check("t3.req_addr", if_req_addr, 64'h8000_1000);

    // 4: redirect in the same cycle as the response handshake, with the slot full
    do_fetch("t4.f0", 64'h8000_1000, 32'h0040_0213);
    id_ready = 1'b0;
    #1;
    check("t4.req_addr", if_req_addr, 64'h8000_1004);
    if_req_ready = 1'b1;
    step();
    if_req_ready = 1'b0;
    if_rsp_valid = 1'b1;
    if_rsp_data  = 32'h0050_0293;
    #1;
    check("t4.rsp_ready_blocked", {63'd0, if_rsp_ready}, 64'd0);
    bj_ena = 1'b1;
    new_pc = 64'h8000_1000;
    #1;
    check("t4.rsp_ready_bj", {63'd0, if_rsp_ready}, 64'd1);
    step();
    bj_ena       = 1'b0;
    if_rsp_valid = 1'b0;
    #1;
    check("t4.id_valid", {63'd0, id_valid}, 64'd0);
    check("t4.req_valid", {63'd0, if_req_valid}, 64'd1);
    check("t4.req_addr", if_req_addr, 64'h8000_1000);

    // 5: asynchronous reset while in S_WAIT
    do_fetch("t5.f0", 64'h8000_1000, 32'h0060_0313);
    if_req_ready = 1'b1;
    step();
    if_req_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("t5.id_valid", {63'd0, id_valid}, 64'd0);
    check("t5.id_pc", id_pc, 64'd0);
    check("t5.id_inst", {32'd0, id_inst}, 64'd0);
    check("t5.req_valid", {63'd0, if_req_valid}, 64'd0);
    check("t5.rsp_ready", {63'd0, if_rsp_ready}, 64'd0);
    step();
    rst = 1'b1;
    id_ready = 1'b1;
    step();
    do_fetch("t5.f1", 64'h8000_0000, 32'h0070_0393);

    // 6: misaligned redirect target
    bj_ena = 1'b1;
    new_pc = 64'h8000_0002;
    #1;
    check("t6.req_valid_bj", {63'd0, if_req_valid}, 64'd0);
    step();
    bj_ena = 1'b0;
    #1;
    check("t6.id_valid", {63'd0, id_valid}, 64'd0);
`ifdef IF_MISALIGN_CHK_EN
    check("t6.misalign", {63'd0, if_misalign}, 64'd1);
    check("t6.halted", {63'd0, if_req_valid}, 64'd0);
    step();
    check("t6.still_halted", {63'd0, if_req_valid}, 64'd0);
`else
    check("t6.req_valid", {63'd0, if_req_valid}, 64'd1);
    check("t6.req_addr", if_req_addr, 64'h8000_0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
